// File: rtl/assoc_pkg.sv
// Shared definitions for the associative search engine.
//   - state encoding constants and the FSM state type
//   - clog2 helper used to size address ports
package assoc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SCAN  = ST_SCAN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  // Ceiling log2, never less than 1 so a 1-bit address is the minimum.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/masked_compare.sv
// Masked equality: hit_c is high when every bit enabled by mask agrees
// between data and key. An all-zero mask matches anything.
//   data  : word under test
//   key   : reference word
//   mask  : per-bit compare enable
//   hit_c : combinational match flag
module masked_compare #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] mask,
  output logic              hit_c
);

  assign hit_c = ~|((data ^ key) & mask);

endmodule

// File: rtl/assoc_search_engine.sv
// Sequential associative search over a synchronous-read memory.
// Scans addresses 0..DEPTH-1, compares each returned word against a masked
// key one cycle after the read, and reports first match address and count.
//   clk, rst            : clock, async active-high reset
//   start/key/mask/mode : search request (sampled in IDLE only)
//   busy                : high outside IDLE
//   mem_rd_en/mem_addr  : read port to memory, mem_data returns next cycle
//   done                : one-cycle completion pulse
//   found/match_addr/match_count : results, held until next accepted start
module assoc_search_engine
  import assoc_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] mask,
  input  logic              mode,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] match_addr,
  output logic [ADDR_W:0]   match_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   key_l;
  logic [DATA_W-1:0]   mask_l;
  logic                mode_l;
  logic                vld_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                hit_c;
  logic                accept;
  logic                take;
  logic                rd_en_nxt;
  logic [ADDR_W-1:0]   addr_nxt;

  masked_compare #(.DATA_W(DATA_W)) u_cmp (
    .data  (mem_data),
    .key   (key_l),
    .mask  (mask_l),
    .hit_c (hit_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, next read address and datapath enables
  always_comb begin
    state_nxt = state;
    rd_en_nxt = 1'b0;
    addr_nxt  = '0;
    accept    = 1'b0;
    // Compares are only honoured while searching; a read still in flight
    // after a first-match exit lands in DONE and is dropped here.
    take      = ((state == SCAN) || (state == DRAIN)) && vld_d && hit_c;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SCAN;
          rd_en_nxt = 1'b1;
        end
      end
      SCAN: begin
        // Early exit takes priority over the end-of-range transition.
        if (take && !mode_l) begin
          state_nxt = DONE;
        end else if (mem_addr == LAST_ADDR) begin
          state_nxt = DRAIN;
        end else begin
          rd_en_nxt = 1'b1;
          addr_nxt  = mem_addr + 1'b1;
        end
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, read pipeline and result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      vld_d       <= 1'b0;
      addr_d      <= '0;
      key_l       <= '0;
      mask_l      <= '0;
      mode_l      <= 1'b0;
      found       <= 1'b0;
      match_addr  <= '0;
      match_count <= '0;
    end else begin
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      mem_rd_en <= rd_en_nxt;
      mem_addr  <= addr_nxt;
      vld_d     <= mem_rd_en;
      addr_d    <= mem_addr;
      if (accept) begin
        key_l       <= key;
        mask_l      <= mask;
        mode_l      <= mode;
        found       <= 1'b0;
        match_addr  <= '0;
        match_count <= '0;
      end else if (take) begin
        if (!found) begin
          found      <= 1'b1;
          match_addr <= addr_d;
        end
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule
